// File: rtl/ila_pkg.sv
// Shared constants for the ILA trigger path: FSM state encoding, trigger
// mode encoding and the default counter width. The host register decoder
// imports the same package so readback values stay consistent.
package ila_pkg;

    // Default width of the pre/post sample counters.
    localparam int ILA_CNT_W  = 12;
    localparam int ILA_MODE_W = 3;
    localparam int ILA_ST_W   = 3;

    // FSM state encoding, also exported on o_state for debug readback.
    localparam logic [2:0] ILA_ST_IDLE         = 3'd0;
    localparam logic [2:0] ILA_ST_PRE_FILL     = 3'd1;
    localparam logic [2:0] ILA_ST_WAIT_TRIG    = 3'd2;
    localparam logic [2:0] ILA_ST_POST_CAPTURE = 3'd3;
    localparam logic [2:0] ILA_ST_DONE         = 3'd4;

    // Trigger mode encoding; codes 6 and 7 are reserved and never fire.
    localparam logic [2:0] ILA_TRIG_RISE = 3'd0;
    localparam logic [2:0] ILA_TRIG_FALL = 3'd1;
    localparam logic [2:0] ILA_TRIG_BOTH = 3'd2;
    localparam logic [2:0] ILA_TRIG_HIGH = 3'd3;
    localparam logic [2:0] ILA_TRIG_LOW  = 3'd4;
    localparam logic [2:0] ILA_TRIG_IMM  = 3'd5;

endpackage : ila_pkg

// File: rtl/ila_trig_match.sv
// Combinational trigger-condition decode. Maps the selected mode onto the
// edge flags and raw level of one probed signal and reports a hit.
module ila_trig_match
    import ila_pkg::*;
#(
    parameter int MODE_W = ILA_MODE_W
) (
    input  logic [MODE_W-1:0] i_mode,
    input  logic              i_signal,
    input  logic              i_post_edge,
    input  logic              i_nedge_edge,
    output logic              o_trig_hit
);

    // Mode decode; reserved codes fall through to "no hit".
    always_comb begin
        o_trig_hit = 1'b0;
        if (i_mode == MODE_W'(ILA_TRIG_RISE)) begin
            o_trig_hit = i_post_edge;
        end else if (i_mode == MODE_W'(ILA_TRIG_FALL)) begin
            o_trig_hit = i_nedge_edge;
        end else if (i_mode == MODE_W'(ILA_TRIG_BOTH)) begin
            o_trig_hit = i_post_edge | i_nedge_edge;
        end else if (i_mode == MODE_W'(ILA_TRIG_HIGH)) begin
            o_trig_hit = i_signal;
        end else if (i_mode == MODE_W'(ILA_TRIG_LOW)) begin
            o_trig_hit = ~i_signal;
        end else if (i_mode == MODE_W'(ILA_TRIG_IMM)) begin
            o_trig_hit = 1'b1;
        end
    end

endmodule : ila_trig_match

// File: rtl/ila_trigger_ctrl.sv
// Trigger and capture-window controller. Sequences pre-trigger fill, trigger
// acceptance and post-trigger capture, driving the sample-buffer write enable.
// Strobe semantics: i_sample_en marks one sample per asserted cycle; every
// window state writes exactly the samples that arrive while it is active, and
// counters advance only on strobe cycles. i_stop and i_reset always win.
module ila_trigger_ctrl
    import ila_pkg::*;
#(
    parameter int CNT_W  = ILA_CNT_W,
    parameter int MODE_W = ILA_MODE_W
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_sample_en,
    input  logic              i_signal,
    input  logic              i_post_edge,
    input  logic              i_nedge_edge,
    input  logic [MODE_W-1:0] i_mode,
    input  logic [CNT_W-1:0]  i_pre_samples,
    input  logic [CNT_W-1:0]  i_post_samples,
    input  logic              i_arm,
    input  logic              i_stop,
    output logic              o_capture_en,
    output logic              o_trigger,
    output logic              o_armed,
    output logic              o_done,
    output logic [2:0]        o_state
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  pre_cnt_q, pre_cnt_d;
    logic [CNT_W-1:0]  post_cnt_q, post_cnt_d;
    logic [MODE_W-1:0] mode_q, mode_d;
    logic [CNT_W-1:0]  post_cfg_q, post_cfg_d;
    logic              trigger_q, trigger_d;
    logic              trig_hit;
    logic              in_window;

    // Mode decode against the configuration latched at arm time.
    ila_trig_match #(
        .MODE_W (MODE_W)
    ) u_trig_match (
        .i_mode       (mode_q),
        .i_signal     (i_signal),
        .i_post_edge  (i_post_edge),
        .i_nedge_edge (i_nedge_edge),
        .o_trig_hit   (trig_hit)
    );

    // Next-state, counter and config-latch logic.
    always_comb begin
        state_d    = state_q;
        pre_cnt_d  = pre_cnt_q;
        post_cnt_d = post_cnt_q;
        mode_d     = mode_q;
        post_cfg_d = post_cfg_q;
        trigger_d  = 1'b0;

        if (i_stop) begin
            // Abort beats arm and trigger on the same cycle.
            state_d    = ILA_ST_IDLE;
            pre_cnt_d  = CNT_ZERO;
            post_cnt_d = CNT_ZERO;
        end else begin
            case (state_q)
                ILA_ST_IDLE, ILA_ST_DONE: begin
                    if (i_arm) begin
                        mode_d     = i_mode;
                        post_cfg_d = i_post_samples;
                        pre_cnt_d  = i_pre_samples;
                        post_cnt_d = CNT_ZERO;
                        state_d    = (i_pre_samples != CNT_ZERO) ? ILA_ST_PRE_FILL
                                                                 : ILA_ST_WAIT_TRIG;
                    end
                end
                ILA_ST_PRE_FILL: begin
                    // Trigger conditions are deliberately ignored here.
                    if (i_sample_en) begin
                        if (pre_cnt_q == CNT_ONE) begin
                            state_d = ILA_ST_WAIT_TRIG;
                        end
                        if (pre_cnt_q != CNT_ZERO) begin
                            pre_cnt_d = pre_cnt_q - CNT_ONE;
                        end
                    end
                end
                ILA_ST_WAIT_TRIG: begin
                    // The triggering sample is written as part of the pre-window.
                    if (trig_hit && i_sample_en) begin
                        trigger_d  = 1'b1;
                        post_cnt_d = (post_cfg_q == CNT_ZERO) ? CNT_ONE : post_cfg_q;
                        state_d    = ILA_ST_POST_CAPTURE;
                    end
                end
                ILA_ST_POST_CAPTURE: begin
                    // Held edge flags are harmless: no trigger evaluation here.
                    if (i_sample_en) begin
                        if (post_cnt_q == CNT_ONE) begin
                            state_d = ILA_ST_DONE;
                        end
                        if (post_cnt_q != CNT_ZERO) begin
                            post_cnt_d = post_cnt_q - CNT_ONE;
                        end
                    end
                end
                default: begin
                    state_d    = ILA_ST_IDLE;
                    pre_cnt_d  = CNT_ZERO;
                    post_cnt_d = CNT_ZERO;
                end
            endcase
        end
    end

    // State, counter and latched-config registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= ILA_ST_IDLE;
            pre_cnt_q  <= CNT_ZERO;
            post_cnt_q <= CNT_ZERO;
            mode_q     <= '0;
            post_cfg_q <= CNT_ZERO;
            trigger_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pre_cnt_q  <= pre_cnt_d;
            post_cnt_q <= post_cnt_d;
            mode_q     <= mode_d;
            post_cfg_q <= post_cfg_d;
            trigger_q  <= trigger_d;
        end
    end

    // Status outputs; capture enable is zero-latency so writes align with samples.
    always_comb begin
        in_window    = (state_q == ILA_ST_PRE_FILL) ||
                       (state_q == ILA_ST_WAIT_TRIG) ||
                       (state_q == ILA_ST_POST_CAPTURE);
        o_capture_en = i_sample_en & in_window;
        o_trigger    = trigger_q;
        o_armed      = (state_q == ILA_ST_PRE_FILL) || (state_q == ILA_ST_WAIT_TRIG);
        o_done       = (state_q == ILA_ST_DONE);
        o_state      = state_q;
    end

endmodule : ila_trigger_ctrl

// File: tb/tb_ila_trigger_ctrl.sv
// Directed bench for ila_trigger_ctrl: linear sequence of steps with
// hand-computed expectations checked by immediate assertions.
module tb_ila_trigger_ctrl;

    logic        i_clk;
    logic        i_reset;
    logic        i_sample_en;
    logic        i_signal;
    logic        i_post_edge;
    logic        i_nedge_edge;
    logic [2:0]  i_mode;
    logic [11:0] i_pre_samples;
    logic [11:0] i_post_samples;
    logic        i_arm;
    logic        i_stop;
    logic        o_capture_en;
    logic        o_trigger;
    logic        o_armed;
    logic        o_done;
    logic [2:0]  o_state;

    int total;
    int bad;

    ila_trigger_ctrl #(
        .CNT_W  (12),
        .MODE_W (3)
    ) dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_sample_en    (i_sample_en),
        .i_signal       (i_signal),
        .i_post_edge    (i_post_edge),
        .i_nedge_edge   (i_nedge_edge),
        .i_mode         (i_mode),
        .i_pre_samples  (i_pre_samples),
        .i_post_samples (i_post_samples),
        .i_arm          (i_arm),
        .i_stop         (i_stop),
        .o_capture_en   (o_capture_en),
        .o_trigger      (o_trigger),
        .o_armed        (o_armed),
        .o_done         (o_done),
        .o_state        (o_state)
    );

    // Clock: 10 ns period.
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Advance one clock; inputs change and outputs settle 1 ns after the edge.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic arm(input logic [2:0] mode, input logic [11:0] pre, input logic [11:0] post);
        i_mode         = mode;
        i_pre_samples  = pre;
        i_post_samples = post;
        i_arm          = 1'b1;
        tick();
        i_arm          = 1'b0;
    endtask

    int caps;
    int trigs;
    logic [2:0] exp_st [10];

    initial begin
        total = 0;
        bad   = 0;
        i_reset = 1'b1; i_sample_en = 1'b0; i_signal = 1'b0;
        i_post_edge = 1'b0; i_nedge_edge = 1'b0; i_mode = 3'd0;
        i_pre_samples = 12'd0; i_post_samples = 12'd0;
        i_arm = 1'b0; i_stop = 1'b0;
        tick();
        tick();
        i_reset = 1'b0;
        #1;

        // Reset state.
        check("rst_state", o_state, 3'd0);
        check("rst_cap", o_capture_en, 1'b0);
        check("rst_trig", o_trigger, 1'b0);
        check("rst_armed", o_armed, 1'b0);
        check("rst_done", o_done, 1'b0);

        // Step 1: rising mode, pre=4, post=3, strobe always on, edge held 2 cycles.
        i_sample_en = 1'b1;
        arm(3'd0, 12'd4, 12'd3);
        i_post_samples = 12'd9;   // must be ignored after arm
        i_pre_samples  = 12'd7;
        check("s1_prefill", o_state, 3'd1);
        check("s1_armed", o_armed, 1'b1);
        caps  = 0;
        trigs = 0;
        for (int i = 0; i < 14; i++) begin
            i_post_edge = (i == 4 || i == 5);
            #1;
            if (o_capture_en) caps++;
            if (o_trigger) trigs++;
            if (i == 4) check("s1_wait_at_edge", o_state, 3'd2);
            if (i == 5) begin
                check("s1_trig_pulse", o_trigger, 1'b1);
                check("s1_post_state", o_state, 3'd3);
            end
            tick();
        end
        i_post_edge = 1'b0;
        #1;
        check("s1_caps", caps, 8);
        check("s1_trigs", trigs, 1);
        check("s1_done", o_done, 1'b1);
        check("s1_done_state", o_state, 3'd4);
        check("s1_done_cap", o_capture_en, 1'b0);

        // Step 2: level-high mode from DONE, pre=0, signal already high.
        i_signal = 1'b1;
        arm(3'd3, 12'd0, 12'd2);
        check("s2_wait", o_state, 3'd2);
        check("s2_cap_trig_sample", o_capture_en, 1'b1);
        check("s2_no_trig_yet", o_trigger, 1'b0);
        tick();
        check("s2_trig", o_trigger, 1'b1);
        check("s2_post", o_state, 3'd3);
        tick();
        check("s2_trig_once", o_trigger, 1'b0);
        check("s2_post2", o_state, 3'd3);
        tick();
        check("s2_done", o_done, 1'b1);
        i_signal = 1'b0;

        // Step 3: rising edge during PRE_FILL ignored; later edge triggers.
        arm(3'd0, 12'd5, 12'd1);
        trigs = 0;
        for (int i = 0; i < 5; i++) begin
            i_post_edge = (i == 1 || i == 2);
            tick();
            if (o_trigger) trigs++;
        end
        i_post_edge = 1'b0;
        check("s3_no_trig_prefill", trigs, 0);
        check("s3_wait", o_state, 3'd2);
        tick();
        tick();
        check("s3_still_wait", o_state, 3'd2);
        i_post_edge = 1'b1;
        tick();
        check("s3_trig", o_trigger, 1'b1);
        check("s3_post", o_state, 3'd3);
        tick();   // edge still high: post=1 finishes, no retrigger
        i_post_edge = 1'b0;
        check("s3_no_retrig", o_trigger, 1'b0);
        check("s3_done", o_state, 3'd4);

        // Step 4: strobe toggling, immediate mode, pre=2, post=2.
        exp_st = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4};
        arm(3'd5, 12'd2, 12'd2);
        for (int i = 0; i < 10; i++) begin
            i_sample_en = (i % 2 == 0);
            #1;
            check($sformatf("s4_state_%0d", i), o_state, exp_st[i]);
            check($sformatf("s4_cap_%0d", i), o_capture_en, (i < 9) ? i_sample_en : 1'b0);
            check($sformatf("s4_trig_%0d", i), o_trigger, (i == 5));
            tick();
        end

        // Step 5: stop together with a hit in WAIT_TRIG.
        i_sample_en = 1'b1;
        arm(3'd2, 12'd0, 12'd3);
        check("s5_wait", o_state, 3'd2);
        i_nedge_edge = 1'b1;
        i_stop = 1'b1;
        i_arm = 1'b1;
        tick();
        i_stop = 1'b0;
        i_arm = 1'b0;
        i_nedge_edge = 1'b0;
        check("s5_idle", o_state, 3'd0);
        check("s5_no_trig", o_trigger, 1'b0);
        check("s5_cap_off", o_capture_en, 1'b0);
        check("s5_armed_off", o_armed, 1'b0);
        tick();
        check("s5_no_late_trig", o_trigger, 1'b0);

        // Step 6: reset during POST_CAPTURE clears the pending trigger pulse.
        arm(3'd4, 12'd0, 12'd4);
        tick();
        check("s6_post", o_state, 3'd3);
        check("s6_trig", o_trigger, 1'b1);
        i_reset = 1'b1;
        i_arm = 1'b1;
        tick();
        i_reset = 1'b0;
        i_arm = 1'b0;
        check("s6_rst_state", o_state, 3'd0);
        check("s6_rst_trig", o_trigger, 1'b0);
        check("s6_rst_cap", o_capture_en, 1'b0);
        check("s6_rst_done", o_done, 1'b0);

        // Step 7: reserved mode never triggers; arm while waiting is ignored.
        arm(3'd6, 12'd0, 12'd1);
        trigs = 0;
        for (int i = 0; i < 6; i++) begin
            i_post_edge  = (i % 2 == 0);
            i_nedge_edge = (i % 2 == 1);
            i_signal     = (i >= 3);
            i_arm        = (i == 2);
            i_mode       = 3'd5;
            tick();
            if (o_trigger) trigs++;
        end
        i_arm = 1'b0;
        i_post_edge = 1'b0;
        i_nedge_edge = 1'b0;
        check("s7_no_trig", trigs, 0);
        check("s7_armed", o_armed, 1'b1);
        check("s7_wait", o_state, 3'd2);
        i_stop = 1'b1;
        tick();
        i_stop = 1'b0;
        check("s7_stop_idle", o_state, 3'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net against a stuck simulation.
    initial begin
        #100000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule : tb_ila_trigger_ctrl
